// File: rtl/decode_issue_ctrl.sv
// Fetch-to-decode sequencing buffer: a small FIFO of instruction/PC pairs.
// Each entry is tagged with its immediate class and legality when it is pushed.
// The head entry and its tags are presented to decode, and the outputs read 0 while the FIFO is empty.
module decode_issue_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_FetchValid,
    output logic             o_FetchReady,
    input  logic [31:0]      i_FetchInstr,
    input  logic [31:0]      i_FetchPc,
    input  logic             i_Stall,
    input  logic             i_Flush,
    output logic             o_DecValid,
    output logic [31:0]      o_DecInstr,
    output logic [31:0]      o_DecPc,
    output logic [2:0]       o_ImmType,
    output logic             o_Illegal,
    output logic [CNT_W-1:0] o_Count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [2:0]       imm_q   [DEPTH];
    logic [DEPTH-1:0] ill_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    // Holds ready low until the first clock edge after reset is released.
    logic             ready_en_q;

    logic       push, pop;
    logic [2:0] push_imm;
    logic       push_ill;

    assign o_DecValid   = (count_q != '0);
    assign o_FetchReady = ready_en_q && (count_q < CNT_W'(DEPTH)) && !i_Flush;
    assign push         = i_FetchValid && o_FetchReady;
    assign pop          = o_DecValid && !i_Stall;
    assign o_Count      = count_q;

    // Classify the incoming instruction's immediate format and legality.
    always_comb begin
        push_imm = IMM_NONE;
        push_ill = 1'b0;
        unique case (i_FetchInstr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: push_imm = IMM_I;
            7'b0100011:                         push_imm = IMM_S;
            7'b1100011:                         push_imm = IMM_B;
            7'b0110111, 7'b0010111:             push_imm = IMM_U;
            7'b1101111:                         push_imm = IMM_J;
            7'b0110011, 7'b1110011, 7'b0001111: push_imm = IMM_NONE;
            default:                            push_ill = 1'b1;
        endcase
        if (i_FetchInstr[1:0] != 2'b11) begin
            push_ill = 1'b1;
        end
    end

    // Pointer, occupancy and ready-enable state; flush overrides push and pop.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (i_Flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop)      count_q <= count_q + CNT_W'(1);
                else if (pop && !push) count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry storage, written at the write pointer on an accepted push.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                imm_q[i]   <= IMM_NONE;
            end
            ill_q <= '0;
        end else if (push) begin
            instr_q[wr_ptr_q] <= i_FetchInstr;
            pc_q[wr_ptr_q]    <= i_FetchPc;
            imm_q[wr_ptr_q]   <= push_imm;
            ill_q[wr_ptr_q]   <= push_ill;
        end
    end

    // Present the head entry, forced to zero when the FIFO is empty.
    always_comb begin
        o_DecInstr = '0;
        o_DecPc    = '0;
        o_ImmType  = IMM_NONE;
        o_Illegal  = 1'b0;
        if (o_DecValid) begin
            o_DecInstr = instr_q[rd_ptr_q];
            o_DecPc    = pc_q[rd_ptr_q];
            o_ImmType  = imm_q[rd_ptr_q];
            o_Illegal  = ill_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed and random bench for decode_issue_ctrl.
// The expected head entry, count and ready come from a queue-based model of the FIFO.
module tb_decode_issue_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             i_Clk = 1'b0;
    logic             i_Rst_n = 1'b0;
    logic             i_FetchValid = 1'b0;
    logic             o_FetchReady;
    logic [31:0]      i_FetchInstr = '0;
    logic [31:0]      i_FetchPc = '0;
    logic             i_Stall = 1'b0;
    logic             i_Flush = 1'b0;
    logic             o_DecValid;
    logic [31:0]      o_DecInstr;
    logic [31:0]      o_DecPc;
    logic [2:0]       o_ImmType;
    logic             o_Illegal;
    logic [CNT_W-1:0] o_Count;

    decode_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_FetchValid (i_FetchValid),
        .o_FetchReady (o_FetchReady),
        .i_FetchInstr (i_FetchInstr),
        .i_FetchPc    (i_FetchPc),
        .i_Stall      (i_Stall),
        .i_Flush      (i_Flush),
        .o_DecValid   (o_DecValid),
        .o_DecInstr   (o_DecInstr),
        .o_DecPc      (o_DecPc),
        .o_ImmType    (o_ImmType),
        .o_Illegal    (o_Illegal),
        .o_Count      (o_Count)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t model_q[$];
    bit     rdy_en = 1'b0;
    int     errors = 0;
    int     checks = 0;

    // Expected {illegal, imm class} from the opcode rules.
    function automatic logic [3:0] ref_class(input logic [31:0] w);
        logic [2:0] imm;
        logic       ill;
        imm = 3'd0;
        ill = 1'b0;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: imm = 3'd1;
            7'h23:               imm = 3'd2;
            7'h63:               imm = 3'd3;
            7'h37, 7'h17:        imm = 3'd4;
            7'h6F:               imm = 3'd5;
            7'h33, 7'h73, 7'h0F: imm = 3'd0;
            default:             ill = 1'b1;
        endcase
        if (w[1:0] != 2'b11) ill = 1'b1;
        return {ill, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        logic [31:0] ei, ep;
        logic [3:0]  cls;
        ei  = '0;
        ep  = '0;
        cls = '0;
        if (model_q.size() > 0) begin
            ei  = model_q[0].instr;
            ep  = model_q[0].pc;
            cls = ref_class(ei);
        end
        check({tag, ".valid"}, 32'(o_DecValid), 32'(model_q.size() > 0));
        check({tag, ".instr"}, o_DecInstr, ei);
        check({tag, ".pc"}, o_DecPc, ep);
        check({tag, ".imm"}, 32'(o_ImmType), 32'(cls[2:0]));
        check({tag, ".ill"}, 32'(o_Illegal), 32'(cls[3]));
        check({tag, ".count"}, 32'(o_Count), 32'(model_q.size()));
    endtask

    // One clock cycle: drive inputs, check ready, clock, update model, check head.
    task automatic step(input string tag, input bit v, input logic [31:0] instr,
                        input logic [31:0] pc, input bit stall, input bit flush);
        bit     exp_rdy, do_push, do_pop;
        entry_t e;
        i_FetchValid = v;
        i_FetchInstr = instr;
        i_FetchPc    = pc;
        i_Stall      = stall;
        i_Flush      = flush;
        #1;
        exp_rdy = rdy_en && (model_q.size() < DEPTH) && !flush;
        check({tag, ".ready"}, 32'(o_FetchReady), 32'(exp_rdy));
        do_push = v && exp_rdy;
        do_pop  = (model_q.size() > 0) && !stall;
        @(posedge i_Clk);
        #1;
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.instr = instr;
                e.pc    = pc;
                model_q.push_back(e);
            end
        end
        check_head(tag);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    logic [31:0] stream [8];
    logic [6:0]  ops [12];
    logic [31:0] r, w;
    logic [2:0]  exp_imm_seq [4];

    initial begin
        stream = '{32'h123450B7, 32'h00001117, 32'h0080006F, 32'h002081B3,
                   32'h00412203, 32'h00100293, 32'hFE000EE3, 32'h00532023};
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                7'h33, 7'h73, 7'h0F, 7'h7F};
        exp_imm_seq = '{3'd4, 3'd4, 3'd5, 3'd0};

        // Reset state
        #3;
        check("rst.ready", 32'(o_FetchReady), 32'h0);
        check_head("rst");
        #19 i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;
        rdy_en = 1'b1;

        // 1: single push of addi
        step("t1.push", 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
        check("t1.imm_i", 32'(o_ImmType), 32'd1);
        idle_step("t1.pop");

        // 2: stall fill then release
        step("t2.sw", 1'b1, 32'h00112023, 32'h200, 1'b1, 1'b0);
        step("t2.beq", 1'b1, 32'hFE000EE3, 32'h204, 1'b1, 1'b0);
        step("t2.full", 1'b1, 32'h00000013, 32'h208, 1'b1, 1'b0);
        check("t2.imm_s", 32'(o_ImmType), 32'd2);
        idle_step("t2.rel");
        check("t2.imm_b", 32'(o_ImmType), 32'd3);
        idle_step("t2.empty");

        // 3: back-to-back streaming across pointer wrap
        for (int i = 0; i < 8; i++) begin
            step("t3.stream", 1'b1, stream[i], 32'h300 + 32'(4 * i), 1'b0, 1'b0);
            if (i < 4) check("t3.imm_seq", 32'(o_ImmType), 32'(exp_imm_seq[i]));
        end
        idle_step("t3.drain");

        // 4: flush with push and pop together
        step("t4.fill", 1'b1, 32'h00000013, 32'h400, 1'b1, 1'b0);
        step("t4.flush", 1'b1, 32'h00000033, 32'h404, 1'b0, 1'b1);
        check("t4.count", 32'(o_Count), 32'h0);
        step("t4.flush_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // 5: illegal detection
        step("t5.ill7f", 1'b1, 32'h0000007F, 32'h500, 1'b0, 1'b0);
        check("t5.ill7f_flag", 32'(o_Illegal), 32'h1);
        step("t5.ill01", 1'b1, 32'h00000001, 32'h504, 1'b0, 1'b0);
        check("t5.ill01_flag", 32'(o_Illegal), 32'h1);
        idle_step("t5.drain");

        // 6: async reset with two entries buffered
        step("t6.a", 1'b1, 32'h00100093, 32'h600, 1'b1, 1'b0);
        step("t6.b", 1'b1, 32'h00200113, 32'h604, 1'b1, 1'b0);
        i_FetchValid = 1'b0;
        #2 i_Rst_n = 1'b0;
        #1;
        model_q.delete();
        rdy_en = 1'b0;
        check("t6.rst_ready", 32'(o_FetchReady), 32'h0);
        check_head("t6.rst");
        #2 i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;
        rdy_en = 1'b1;
        step("t6.new", 1'b1, 32'h00300193, 32'h700, 1'b0, 1'b0);
        check("t6.new_pc", o_DecPc, 32'h700);
        idle_step("t6.drain");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            w = $urandom;
            if (r[3:0] != 4'hF) w[6:0] = ops[r[7:4] % 12];
            step("rnd", r[8] | r[9], w, $urandom, r[10] & r[11], r[16:12] == 5'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Sequencing buffer between instruction fetch and the decode/immediate-generation stage of the RV32I core.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and buffers them in a small FIFO.
- Classifies each instruction's immediate format at push time and presents the FIFO head, with its class, to decode, the immediate generator and the hazard unit.
- Handles decode stalls and pipeline flushes (branch/jump redirect).

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- i_Clk  input  1  core clock; all state updates on its rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_FetchValid  input  1  fetch presents a valid instruction.
- o_FetchReady  output  1  block can accept an instruction this cycle.
- i_FetchInstr  input  32  fetched instruction word.
- i_FetchPc  input  32  PC of the fetched instruction.
- i_Stall  input  1  decode cannot consume the head this cycle.
- i_Flush  input  1  discard all buffered instructions.
- o_DecValid  output  1  head entry valid.
- o_DecInstr  output  32  head instruction, fed to the immediate generator and decode.
- o_DecPc  output  32  head PC.
- o_ImmType  output  3  head immediate class: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- o_Illegal  output  1  head opcode unrecognised, or instr[1:0] != 2'b11.
- o_Count  output  CNT_W  current occupancy.

Behaviour:
Reset
- i_Rst_n low asynchronously empties the FIFO and zeroes pointers.
- Outputs while in reset: o_DecValid=0, o_FetchReady=0, o_DecInstr=0, o_DecPc=0, o_ImmType=0, o_Illegal=0, o_Count=0.
- o_FetchReady rises in the first cycle after reset deasserts.

Handshake
- Push when i_FetchValid && o_FetchReady.
- Pop when o_DecValid && !i_Stall.
- o_FetchReady = (count < DEPTH) && !i_Flush && !reset. There is no combinational pass-through: when full, a pop does not free a slot in the same cycle.

Latency and ordering
- A pushed instruction is visible at the head no earlier than the next cycle.
- Outputs come from registered storage and the registered count only; there is no combinational path from the fetch inputs to the head outputs.
- Order is strictly FIFO.

Simultaneous events
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- Pushes into the full FIFO are impossible by the ready rule.
- Pops from the empty FIFO are impossible because o_DecValid=0.

Classification at push, stored alongside the entry, keyed on opcode instr[6:0]:
- 0010011, 0000011, 1100111 → I
- 0100011 → S
- 1100011 → B
- 0110111, 0010111 → U
- 1101111 → J
- 0110011, 1110011, 0001111 → NONE, legal
- any other opcode → NONE, Illegal=1
- instr[1:0] != 2'b11 → Illegal=1 regardless of opcode

Flush
- i_Flush high: the next cycle has count=0, o_DecValid=0 and both pointers reset.
- Flush has priority over a same-cycle push and pop. No push can be accepted in that cycle because ready is low.
- Flush while empty is harmless.

Stall
- While i_Stall is high, all head outputs hold stable.
- Pushes continue until the FIFO is full.

Wrap-around
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full/empty is determined by the count, not by pointer comparison.

Outputs while empty
- o_DecInstr, o_DecPc, o_ImmType and o_Illegal are don't-care-free: they are driven 0.

Reset mid-operation
- Asserting i_Rst_n low with entries buffered clears them immediately. No entry is presented after reset.

Test Plan:
1. Reset then single push: i_FetchInstr=32'h00500093 (addi), PC=32'h100, i_Stall=0 → next cycle o_DecValid=1, o_ImmType=1, o_Illegal=0, o_DecPc=32'h100; following cycle o_Count=0.
2. Stall fill: i_Stall=1, push 32'h00112023 (sw), then 32'hFE000EE3 (beq) → o_Count=2, o_FetchReady=0, head ImmType=2. Release stall → ImmType=3 next cycle, then empty.
3. Back-to-back streaming: push every cycle with i_Stall=0 for 8 instructions (lui, auipc, jal, add, …) → no bubbles after the first; ImmType sequence 4,4,5,0,…; order preserved across pointer wrap.
4. Flush with push and pop together: FIFO holds 1 entry, push valid and i_Flush=1 in the same cycle → next cycle o_Count=0, o_DecValid=0; the pushed instruction is not accepted (ready was 0).
5. Illegal detection: push 32'h0000007F → o_Illegal=1, o_ImmType=0. Push 32'h00000001 → o_Illegal=1.
6. Async reset mid-operation: with 2 entries, pulse i_Rst_n low between clock edges → outputs zero immediately without a clock edge. After release, the first new push is the next head.
